// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Load misses take two stall cycles (IDLE miss, then FILL); stores are always single-cycle.
module dcache_direct #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  write_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  stall_o,
  output logic                  mem_write_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                  state_q, state_d;
  logic [SETS-1:0]         valid_q;
  logic [TAG_W-1:0]        tag_mem  [SETS];
  logic [DATA_WIDTH-1:0]   data_mem [SETS];
  logic [ADDR_WIDTH-1:0]   fill_addr_q;
  logic                    replay_q;
  logic [31:0]             hit_cnt_q, miss_cnt_q;

  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [IDX_W-1:0]        req_idx, fill_idx;
  logic [TAG_W-1:0]        req_tag, fill_tag;
  logic                    is_load, is_store, hit;

  assign req_addr = addr_i & ~ADDR_WIDTH'(3);
  assign req_idx  = req_addr[IDX_W+1:2];
  assign req_tag  = req_addr[ADDR_WIDTH-1:IDX_W+2];
  assign fill_idx = fill_addr_q[IDX_W+1:2];
  assign fill_tag = fill_addr_q[ADDR_WIDTH-1:IDX_W+2];

  assign is_load  = req_valid_i & ~write_en_i;
  assign is_store = req_valid_i & write_en_i;
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  assign read_data_o      = data_mem[req_idx];
  assign mem_write_data_o = write_data_i;
  assign hit_count_o      = hit_cnt_q;
  assign miss_count_o     = miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_load && !hit) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o        = 1'b0;
    mem_write_en_o = 1'b0;
    mem_addr_o     = req_addr;
    case (state_q)
      IDLE: begin
        stall_o        = is_load & ~hit;
        mem_write_en_o = is_store;
      end
      FILL: begin
        stall_o    = 1'b1;
        mem_addr_o = fill_addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      fill_addr_q <= '0;
      replay_q    <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else if (state_q == FILL) begin
      valid_q[fill_idx] <= 1'b1;
      replay_q          <= 1'b1;
    end else begin
      replay_q <= 1'b0;
      if (is_load && !hit) begin
        fill_addr_q <= req_addr;
        miss_cnt_q  <= miss_cnt_q + 32'd1;
      end
      // The hit that completes a fill is the original miss, so it is not counted again.
      if (is_load && hit && !replay_q) hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == FILL) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_read_data_i;
    end else if (is_store && hit) begin
      data_mem[req_idx] <= write_data_i;
    end
  end
endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct: the driver predicts each response from a line-residency
// model plus a reference memory, and the monitor compares whenever an access completes.
module tb_dcache_direct;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, write_en_i;
  logic [31:0] addr_i, write_data_i, read_data_o;
  logic        stall_o, mem_write_en_o;
  logic [31:0] mem_addr_o, mem_write_data_o, mem_read_data_i;
  logic [31:0] hit_count_o, miss_count_o;

  dcache_direct #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SETS(256)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .write_en_i(write_en_i),
    .addr_i(addr_i), .write_data_i(write_data_i), .read_data_o(read_data_o),
    .stall_o(stall_o), .mem_write_en_o(mem_write_en_o), .mem_addr_o(mem_addr_o),
    .mem_write_data_o(mem_write_data_o), .mem_read_data_i(mem_read_data_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk = ~clk;

  // Environment memory (written by the DUT) and reference memory (written by the driver).
  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];

  function automatic int unsigned wi(input logic [31:0] a);
    logic [31:0] d;
    d = (a - BASE) >> 2;
    return int'(d[11:0]);
  endfunction

  assign mem_read_data_i = mem[wi(mem_addr_o)];

  always @(posedge clk) if (mem_write_en_o) mem[wi(mem_addr_o)] <= mem_write_data_o;

  typedef struct {
    bit          is_store;
    logic [31:0] addr;
    logic [31:0] data;
    int          stalls;
    logic [31:0] hits;
    logic [31:0] misses;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Residency model: which word address (if any) occupies each set.
  bit          res_valid [256];
  logic [29:0] res_word  [256];
  logic [31:0] m_hits, m_misses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) res_valid[i] = 1'b0;
    m_hits = '0;
    m_misses = '0;
  endtask

  // Monitor: pops one expectation per completed access.
  int stall_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_i || !req_valid_i) begin
      stall_run = 0;
    end else if (!write_en_i && stall_o) begin
      stall_run++;
    end else if (sb.size() == 0) begin
      check("unexpected_access", 32'd1, 32'd0);
      stall_run = 0;
    end else begin
      e = sb.pop_front();
      if (e.is_store) begin
        check("store_kind", {31'd0, write_en_i}, 32'd1);
        check("store_stall", {31'd0, stall_o}, 32'd0);
        check("store_mem_we", {31'd0, mem_write_en_o}, 32'd1);
        check("store_mem_addr", mem_addr_o, e.addr);
        check("store_mem_data", mem_write_data_o, e.data);
      end else begin
        check("load_kind", {31'd0, write_en_i}, 32'd0);
        check("load_data", read_data_o, e.data);
        check("load_stall_cycles", stall_run, e.stalls);
        check("load_mem_addr", mem_addr_o, e.addr);
        check("load_mem_we", {31'd0, mem_write_en_o}, 32'd0);
        check("hit_count", hit_count_o, e.hits);
        check("miss_count", miss_count_o, e.misses);
      end
      stall_run = 0;
    end
  end

  task automatic do_load(input logic [31:0] a);
    exp_t e;
    int unsigned idx;
    bit done;
    idx = int'(a[9:2]);
    e.is_store = 1'b0;
    e.addr     = a & ~32'd3;
    e.data     = ref_mem[wi(a)];
    if (res_valid[idx] && res_word[idx] == a[31:2]) begin
      e.stalls = 0;
      e.hits   = m_hits;
      e.misses = m_misses;
      m_hits   = m_hits + 32'd1;
    end else begin
      m_misses       = m_misses + 32'd1;
      res_valid[idx] = 1'b1;
      res_word[idx]  = a[31:2];
      e.stalls = 2;
      e.hits   = m_hits;
      e.misses = m_misses;
    end
    sb.push_back(e);
    req_valid_i = 1'b1; write_en_i = 1'b0; addr_i = a;
    done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge clk);
      if (!stall_o) done = 1'b1;
    end
    if (!done) check("load_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.is_store = 1'b1;
    e.addr     = a & ~32'd3;
    e.data     = d;
    e.stalls   = 0;
    e.hits     = m_hits;
    e.misses   = m_misses;
    ref_mem[wi(a)] = d;
    sb.push_back(e);
    req_valid_i = 1'b1; write_en_i = 1'b1; addr_i = a; write_data_i = d;
    @(posedge clk); #1;
    req_valid_i = 1'b0; write_en_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      ref_mem[i] = mem[i];
    end
    mem[wi(32'h0001_0000)]     = 32'hDEAD_BEEF;
    ref_mem[wi(32'h0001_0000)] = 32'hDEAD_BEEF;
    model_reset();
    rst_i = 1'b1; req_valid_i = 1'b0; write_en_i = 1'b0;
    addr_i = BASE; write_data_i = '0;
    #12;
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_mem_we", {31'd0, mem_write_en_o}, 32'd0);
    check("reset_hits", hit_count_o, 32'd0);
    check("reset_misses", miss_count_o, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Cold miss, hit, store hit, store miss, conflict evictions.
    do_load(32'h0001_0000);
    do_load(32'h0001_0000);
    do_store(32'h0001_0000, 32'h1234_5678);
    do_load(32'h0001_0000);
    do_store(32'h0001_0020, 32'hCAFE_F00D);
    do_load(32'h0001_0020);
    do_load(32'h0001_0800);
    do_load(32'h0001_0000);
    do_load(32'h0001_0400);
    do_load(32'h0001_0000);

    // Reset while a fill is in flight; the fill is discarded.
    req_valid_i = 1'b1; write_en_i = 1'b0; addr_i = 32'h0001_0004;
    @(negedge clk);
    check("midfill_miss_stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("fill_holds_stall", {31'd0, stall_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("midfill_reset_stall", {31'd0, stall_o}, 32'd0);
    check("midfill_reset_mem_we", {31'd0, mem_write_en_o}, 32'd0);
    check("midfill_reset_hits", hit_count_o, 32'd0);
    check("midfill_reset_misses", miss_count_o, 32'd0);
    rst_i = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_load(32'h0001_0004);
    do_load(32'h0001_0007);
    do_load(32'h0001_0000);

    // Randomized mix over a few sets and tags to provoke hits, misses and evictions.
    for (int k = 0; k < 300; k++) begin
      a = BASE + ($urandom_range(0, 3) * 32'h400) + ($urandom_range(0, 7) * 32'd4)
          + $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r < 3)       do_store(a, $urandom);
      else if (r == 9) begin @(posedge clk); #1; end
      else             do_load(a);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
